// File: rtl/y_serial_adder.sv
// Multi-cycle add/subtract unit: DIGIT bits per clock, LSB digit first, over WIDTH/DIGIT cycles.
// Ready/valid on both sides; the inter-digit carry lives in a single register.
module y_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] da, db;
  logic [DIGIT:0]   dsum;
  logic             last;
  logic [WIDTH-1:0] zr;
  logic             coutr, ovfr;

  always_comb begin
    da   = opa[cnt*DIGIT +: DIGIT];
    db   = opb[cnt*DIGIT +: DIGIT];
    dsum = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry};
    last = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      zr    <= '0;
      coutr <= 1'b0;
      ovfr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          zr[cnt*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
          carry <= dsum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (last) begin
            coutr <= dsum[DIGIT];
            // carry-into-MSB ^ cout, expressed via the operand and result sign bits
            ovfr  <= (opa[WIDTH-1] == opb[WIDTH-1]) && (dsum[DIGIT-1] != opa[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign z         = zr;
  assign cout      = coutr;
  assign ovf       = ovfr;

endmodule

// File: tb/tb_y_serial_adder.sv
// Bench for y_serial_adder: four instances (DIGIT 1/4/8/32) driven in lockstep with
// directed vectors, backpressure and mid-operation reset sequences, and a random sweep.
module tb_y_serial_adder;

  localparam int W  = 32;
  localparam int NI = 4;

  function automatic int dg(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : (i == 2) ? 8 : 32;
  endfunction

  logic          clk = 1'b0;
  logic          reset, in_valid, cin, sub, out_ready;
  logic [W-1:0]  a, b;
  logic [NI-1:0] in_ready_v, out_valid_v, cout_v, ovf_v, busy_v;
  logic [W-1:0]  z_v [NI];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      y_serial_adder #(.WIDTH(W), .DIGIT(dg(g))) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[g]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[g]),
        .out_ready(out_ready), .z(z_v[g]), .cout(cout_v[g]), .ovf(ovf_v[g]),
        .busy(busy_v[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] z;
    logic         cout, ovf;
  } vec_t;

  task automatic chk(input string nm, input int idx, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s [DIGIT=%0d] got=%0h expected=%0h", nm, dg(idx), got, exp);
    else
      n_pass++;
  endtask

  // Reference: {ovf, cout, z}, ovf taken as carry-into-MSB ^ carry-out.
  function automatic logic [W+1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bi,
                                         input logic ci, input logic sb);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   full;
    logic [W-1:0] low;
    bb   = sb ? ~bi : bi;
    cc   = sb ? ~ci : ci;
    full = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cc};
    low  = {1'b0, aa[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, cc};
    return {low[W-1] ^ full[W], full[W], full[W-1:0]};
  endfunction

  task automatic wait_idle();
    for (int c = 0; c < 200; c++) begin
      if (&in_ready_v) return;
      @(posedge clk); #1;
    end
    chk("idle_timeout", 0, W'(in_ready_v), W'({NI{1'b1}}));
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                       input logic tc, input logic ts,
                       input logic [W-1:0] ez, input logic ec, input logic eo);
    int            lat [NI];
    logic [NI-1:0] got;
    logic [W-1:0]  zc [NI];
    logic [NI-1:0] cc, oc;
    wait_idle();
    a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb2; cin = ~tc; sub = ~ts;
    got = '0; cc = '0; oc = '0;
    for (int i = 0; i < NI; i++) begin lat[i] = 0; zc[i] = '0; end
    for (int c = 1; c <= 40 && got != '1; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++)
        if (!got[i] && out_valid_v[i]) begin
          got[i] = 1'b1; lat[i] = c; zc[i] = z_v[i]; cc[i] = cout_v[i]; oc[i] = ovf_v[i];
        end
    end
    for (int i = 0; i < NI; i++) begin
      chk({nm, ".lat"},  i, W'(lat[i]), W'(W / dg(i)));
      chk({nm, ".z"},    i, zc[i], ez);
      chk({nm, ".cout"}, i, W'(cc[i]), W'(ec));
      chk({nm, ".ovf"},  i, W'(oc[i]), W'(eo));
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t          tv [9];
    logic [W+1:0]  m;
    logic [W-1:0]  ra, rb;
    logic          rc, rs;
    logic [NI-1:0] allv;

    tv[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tv[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tv[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tv[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tv[4] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    tv[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tv[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tv[7] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0};
    tv[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("rst.in_ready",  i, W'(in_ready_v[i]),  W'(1'b1));
      chk("rst.out_valid", i, W'(out_valid_v[i]), W'(1'b0));
      chk("rst.busy",      i, W'(busy_v[i]),      W'(1'b0));
      chk("rst.z",         i, z_v[i],             '0);
      chk("rst.cout",      i, W'(cout_v[i]),      W'(1'b0));
      chk("rst.ovf",       i, W'(ovf_v[i]),       W'(1'b0));
    end

    for (int k = 0; k < 9; k++)
      do_op($sformatf("vec%0d", k), tv[k].a, tv[k].b, tv[k].cin, tv[k].sub,
            tv[k].z, tv[k].cout, tv[k].ovf);

    // Backpressure: result held, in_ready low, stray in_valid ignored.
    wait_idle();
    out_ready = 1'b0;
    a = 32'h1; b = 32'h2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    allv = '0;
    for (int c = 0; c < 40 && allv != '1; c++) begin
      @(posedge clk); #1;
      allv = out_valid_v;
    end
    chk("bp.all_valid", 0, W'(allv), W'({NI{1'b1}}));
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1111_1111; sub = k[0];
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        chk("bp.out_valid", i, W'(out_valid_v[i]), W'(1'b1));
        chk("bp.in_ready",  i, W'(in_ready_v[i]),  W'(1'b0));
        chk("bp.z",         i, z_v[i],             32'h3);
        chk("bp.cout",      i, W'(cout_v[i]),      W'(1'b0));
        chk("bp.ovf",       i, W'(ovf_v[i]),       W'(1'b0));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      chk("bp.rel_in_ready",  i, W'(in_ready_v[i]),  W'(1'b1));
      chk("bp.rel_out_valid", i, W'(out_valid_v[i]), W'(1'b0));
    end

    // Reset after two RUN edges aborts the operation.
    wait_idle();
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("mrst.out_valid", i, W'(out_valid_v[i]), W'(1'b0));
      chk("mrst.in_ready",  i, W'(in_ready_v[i]),  W'(1'b1));
      chk("mrst.busy",      i, W'(busy_v[i]),      W'(1'b0));
      chk("mrst.z",         i, z_v[i],             '0);
    end
    do_op("post_rst", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, 32'h1010_1010, 1'b0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      m  = model(ra, rb, rc, rs);
      do_op("rand", ra, rb, rc, rs, m[W-1:0], m[W], m[W+1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
